// File: rtl/chip8_mem_arbiter_pkg.sv
// chip8_mem_pkg: shared constants for the chip8
// RAM arbiter and its requesters.
package chip8_mem_pkg;

  localparam int REQ_CPU = 0;
  localparam int REQ_PPU = 1;
  localparam int REQ_VID = 2;
  localparam int NUM_REQ = 3;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 8;

  localparam logic [11:0] FB_BASE = 12'hF00;

endpackage

// File: rtl/chip8_mem_arbiter_if.sv
// chip8_mem_arbiter_if: requester and RAM signals
// around the chip8 RAM arbiter.
interface chip8_mem_arbiter_if #(
  parameter int ADDR_W = chip8_mem_pkg::DEF_ADDR_W,
  parameter int DATA_W = chip8_mem_pkg::DEF_DATA_W
);

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;

  logic              ppu_req;
  logic              ppu_we;
  logic [ADDR_W-1:0] ppu_addr;
  logic [DATA_W-1:0] ppu_wdata;
  logic              ppu_gnt;
  logic              ppu_rvalid;

  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_gnt;
  logic              vid_rvalid;

  logic [DATA_W-1:0] rdata;

  logic [ADDR_W-1:0] mem_read_address;
  logic [ADDR_W-1:0] mem_write_address;
  logic [DATA_W-1:0] mem_d;
  logic              mem_we;
  logic [DATA_W-1:0] mem_q;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output ppu_req, ppu_we, ppu_addr, ppu_wdata,
    output vid_req, vid_addr,
    output mem_q,
    input  cpu_gnt, cpu_rvalid,
    input  ppu_gnt, ppu_rvalid,
    input  vid_gnt, vid_rvalid,
    input  rdata,
    input  mem_read_address, mem_write_address,
    input  mem_d, mem_we
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  ppu_req, ppu_we, ppu_addr, ppu_wdata,
    input  vid_req, vid_addr,
    input  mem_q,
    output cpu_gnt, cpu_rvalid,
    output ppu_gnt, ppu_rvalid,
    output vid_gnt, vid_rvalid,
    output rdata,
    output mem_read_address, mem_write_address,
    output mem_d, mem_we
  );

endinterface

// File: rtl/chip8_mem_arbiter_rr_pick2.sv
// chip8_rr_pick2: CPU/ppu round-robin picker with
// per-requester starvation counters.
module chip8_rr_pick2
  import chip8_mem_pkg::*;
#(
  parameter int MAX_WAIT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       block,
  output logic [1:0] gnt,
  output logic       forced
);

  localparam int W = $clog2(MAX_WAIT + 1);
  localparam logic [W-1:0] SAT = W'(MAX_WAIT);

  logic [W-1:0] wait_q [2];
  logic         rr_last;
  logic [1:0]   sat;
  logic [1:0]   pick;

  assign sat[REQ_CPU] = req[REQ_CPU]
                     && (wait_q[REQ_CPU] == SAT);
  assign sat[REQ_PPU] = req[REQ_PPU]
                     && (wait_q[REQ_PPU] == SAT);
  assign forced = |sat;
  assign gnt    = pick & {2{rst_n}};

  // rr_last = 1 means the ppu won the previous tie
  always_comb begin
    pick = '0;
    priority case (1'b1)
      sat[REQ_CPU]: pick = 2'b01;
      sat[REQ_PPU]: pick = 2'b10;
      block:        pick = 2'b00;
      &req:         pick = rr_last ? 2'b01 : 2'b10;
      req[REQ_CPU]: pick = 2'b01;
      req[REQ_PPU]: pick = 2'b10;
      default:      pick = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last   <= 1'b1;
      wait_q[0] <= '0;
      wait_q[1] <= '0;
    end else begin
      if (gnt[REQ_CPU]) begin
        rr_last <= 1'b0;
      end else if (gnt[REQ_PPU]) begin
        rr_last <= 1'b1;
      end
      for (int i = 0; i < 2; i++) begin
        if (req[i] && !gnt[i]) begin
          wait_q[i] <= (wait_q[i] == SAT)
                     ? SAT : wait_q[i] + 1'b1;
        end else begin
          wait_q[i] <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/chip8_mem_arbiter.sv
// chip8_mem_arbiter: shares chip8_ram between CPU,
// ppu sprite engine and video scanout.
module chip8_mem_arbiter
  import chip8_mem_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int VIDEO_BURST = 4,
  parameter int MAX_WAIT    = 8
) (
  input logic                clk,
  input logic                reset,
  chip8_mem_arbiter_if.slave bus
);

  localparam int RUN_W = $clog2(VIDEO_BURST + 1);
  localparam logic [RUN_W-1:0] RUN_MAX =
    RUN_W'(VIDEO_BURST);

  logic [RUN_W-1:0]   vid_run;
  logic               vid_ok;
  logic               forced;
  logic [1:0]         rr_gnt;
  logic [NUM_REQ-1:0] gnt;
  logic [NUM_REQ-1:0] rvalid_q;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic               sel_we;
  logic               rd_go;
  logic               wr_go;
  logic [ADDR_W-1:0]  rd_addr_q;
  logic [ADDR_W-1:0]  wr_addr_q;
  logic [DATA_W-1:0]  wd_q;

  // video yields once its burst is spent and
  // someone else is waiting
  assign vid_ok = bus.vid_req
    && !((vid_run == RUN_MAX)
         && (bus.cpu_req || bus.ppu_req));

  chip8_rr_pick2 #(
    .MAX_WAIT (MAX_WAIT)
  ) u_pick (
    .clk    (clk),
    .rst_n  (reset),
    .req    ({bus.ppu_req, bus.cpu_req}),
    .block  (vid_ok),
    .gnt    (rr_gnt),
    .forced (forced)
  );

  assign gnt[REQ_CPU] = rr_gnt[REQ_CPU];
  assign gnt[REQ_PPU] = rr_gnt[REQ_PPU];
  assign gnt[REQ_VID] = reset && vid_ok && !forced;

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    unique case (1'b1)
      gnt[REQ_CPU]: begin
        sel_addr  = bus.cpu_addr;
        sel_wdata = bus.cpu_wdata;
        sel_we    = bus.cpu_we;
      end
      gnt[REQ_PPU]: begin
        sel_addr  = bus.ppu_addr;
        sel_wdata = bus.ppu_wdata;
        sel_we    = bus.ppu_we;
      end
      gnt[REQ_VID]: begin
        sel_addr  = bus.vid_addr;
      end
      default: ;
    endcase
  end

  assign rd_go = (|gnt) && !sel_we;
  assign wr_go = sel_we;

  // RAM ports hold their last address when idle
  assign bus.mem_we = wr_go;
  assign bus.mem_read_address =
    rd_go ? sel_addr : rd_addr_q;
  assign bus.mem_write_address =
    wr_go ? sel_addr : wr_addr_q;
  assign bus.mem_d = wr_go ? sel_wdata : wd_q;

  assign bus.cpu_gnt    = gnt[REQ_CPU];
  assign bus.ppu_gnt    = gnt[REQ_PPU];
  assign bus.vid_gnt    = gnt[REQ_VID];
  assign bus.cpu_rvalid = rvalid_q[REQ_CPU];
  assign bus.ppu_rvalid = rvalid_q[REQ_PPU];
  assign bus.vid_rvalid = rvalid_q[REQ_VID];
  assign bus.rdata      = bus.mem_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vid_run   <= '0;
      rvalid_q  <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wd_q      <= '0;
    end else begin
      rvalid_q <= rd_go ? gnt : '0;
      if (rd_go) begin
        rd_addr_q <= sel_addr;
      end
      if (wr_go) begin
        wr_addr_q <= sel_addr;
        wd_q      <= sel_wdata;
      end
      if (gnt[REQ_VID]) begin
        vid_run <= (vid_run == RUN_MAX)
                 ? RUN_MAX : vid_run + 1'b1;
      end else begin
        vid_run <= '0;
      end
    end
  end

endmodule

// File: tb/tb_chip8_mem_arbiter.sv
// tb_chip8_mem_arbiter: two arbiter instances
// (4/8 and 8/2 burst/wait) against a behavioural model.
module tb_chip8_mem_arbiter;
  import chip8_mem_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  bit rnd_on = 1'b0;
  int dens = 50;
  int vdens = 50;

  logic        cpu_req [2];
  logic        ppu_req [2];
  logic        vid_req [2];
  logic        cpu_we [2];
  logic        ppu_we [2];
  logic [11:0] cpu_addr [2];
  logic [11:0] ppu_addr [2];
  logic [11:0] vid_addr [2];
  logic [7:0]  cpu_wdata [2];
  logic [7:0]  ppu_wdata [2];

  wire [2:0]  gnt [2];
  wire [2:0]  rv [2];
  wire [7:0]  rdata [2];
  wire [7:0]  md [2];
  wire [11:0] mra [2];
  wire [11:0] mwa [2];
  wire        mwe [2];

  function automatic logic [7:0] init_byte(int i);
    if (i == 'h200) return 8'hA2;
    return 8'(i * 13 + 7);
  endfunction

  function automatic int vb_of(int k);
    return (k == 0) ? 4 : 8;
  endfunction

  function automatic int mw_of(int k);
    return (k == 0) ? 8 : 2;
  endfunction

  for (genvar k = 0; k < 2; k++) begin : g
    chip8_mem_arbiter_if #(.ADDR_W(12), .DATA_W(8)) bus ();
    logic [7:0] ram [4096];
    logic [7:0] q;

    chip8_mem_arbiter #(
      .ADDR_W      (12),
      .DATA_W      (8),
      .VIDEO_BURST ((k == 0) ? 4 : 8),
      .MAX_WAIT    ((k == 0) ? 8 : 2)
    ) dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus)
    );

    assign bus.cpu_req   = cpu_req[k];
    assign bus.cpu_we    = cpu_we[k];
    assign bus.cpu_addr  = cpu_addr[k];
    assign bus.cpu_wdata = cpu_wdata[k];
    assign bus.ppu_req   = ppu_req[k];
    assign bus.ppu_we    = ppu_we[k];
    assign bus.ppu_addr  = ppu_addr[k];
    assign bus.ppu_wdata = ppu_wdata[k];
    assign bus.vid_req   = vid_req[k];
    assign bus.vid_addr  = vid_addr[k];
    assign bus.mem_q     = q;

    assign gnt[k] = {bus.vid_gnt, bus.ppu_gnt, bus.cpu_gnt};
    assign rv[k]  = {bus.vid_rvalid, bus.ppu_rvalid,
                     bus.cpu_rvalid};
    assign rdata[k] = bus.rdata;
    assign md[k]    = bus.mem_d;
    assign mra[k]   = bus.mem_read_address;
    assign mwa[k]   = bus.mem_write_address;
    assign mwe[k]   = bus.mem_we;

    initial begin
      for (int i = 0; i < 4096; i++) ram[i] = init_byte(i);
      q = 8'h00;
    end

    // chip8_ram stand-in: 1-cycle synchronous read
    always @(posedge clk) begin
      if (bus.mem_we) ram[bus.mem_write_address] <= bus.mem_d;
      q <= ram[bus.mem_read_address];
    end
  end

  // behavioural model state
  int          m_vr [2];
  int          m_cw [2];
  int          m_pw [2];
  bit          m_rrp [2];
  bit [2:0]    m_pend [2];
  bit [2:0]    last_g [2];
  logic [7:0]  m_pdata [2];
  logic [7:0]  m_wd [2];
  logic [11:0] m_ra [2];
  logic [11:0] m_wa [2];
  logic [7:0]  shm [2][4096];

  task automatic chk(string nm, int k,
                     logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] t=%0t: got %0h expected %0h",
               nm, k, $time, act, exp);
    end
  endtask

  task automatic mreset(int k);
    m_vr[k] = 0;
    m_cw[k] = 0;
    m_pw[k] = 0;
    m_rrp[k] = 1'b1;
    m_pend[k] = '0;
    m_pdata[k] = '0;
    m_ra[k] = '0;
    m_wa[k] = '0;
    m_wd[k] = '0;
    last_g[k] = '0;
  endtask

  function automatic bit [2:0] exp_pick(int k);
    bit c = cpu_req[k];
    bit p = ppu_req[k];
    bit v = vid_req[k];
    if (c && m_cw[k] == mw_of(k)) return 3'b001;
    if (p && m_pw[k] == mw_of(k)) return 3'b010;
    if (v && !(m_vr[k] == vb_of(k) && (c || p))) return 3'b100;
    if (c && p) return m_rrp[k] ? 3'b001 : 3'b010;
    if (c) return 3'b001;
    if (p) return 3'b010;
    return 3'b000;
  endfunction

  task automatic step(int k);
    bit [2:0] eg;
    bit wr;
    logic [11:0] a;
    logic [7:0] wd;
    if (!rst_n) begin
      mreset(k);
      chk("rst_gnt", k, gnt[k], 0);
      chk("rst_rvalid", k, rv[k], 0);
      chk("rst_mem_we", k, mwe[k], 0);
      chk("rst_raddr", k, mra[k], 0);
      chk("rst_waddr", k, mwa[k], 0);
      chk("rst_mem_d", k, md[k], 0);
      return;
    end
    eg = exp_pick(k);
    chk("gnt", k, gnt[k], eg);
    chk("rvalid", k, rv[k], m_pend[k]);
    if (m_pend[k] != 0) chk("rdata", k, rdata[k], m_pdata[k]);
    a = eg[0] ? cpu_addr[k] : eg[1] ? ppu_addr[k] : vid_addr[k];
    wd = eg[0] ? cpu_wdata[k] : ppu_wdata[k];
    wr = (eg[0] && cpu_we[k]) || (eg[1] && ppu_we[k]);
    m_pend[k] = '0;
    if (wr) begin
      m_wa[k] = a;
      m_wd[k] = wd;
      shm[k][a] = wd;
    end else if (eg != 0) begin
      m_ra[k] = a;
      m_pend[k] = eg;
      m_pdata[k] = shm[k][a];
    end
    chk("mem_we", k, mwe[k], wr);
    chk("raddr", k, mra[k], m_ra[k]);
    chk("waddr", k, mwa[k], m_wa[k]);
    chk("mem_d", k, md[k], m_wd[k]);
    if (eg[2]) m_vr[k] = (m_vr[k] < vb_of(k)) ? m_vr[k] + 1 : m_vr[k];
    else m_vr[k] = 0;
    if (cpu_req[k] && !eg[0])
      m_cw[k] = (m_cw[k] < mw_of(k)) ? m_cw[k] + 1 : m_cw[k];
    else m_cw[k] = 0;
    if (ppu_req[k] && !eg[1])
      m_pw[k] = (m_pw[k] < mw_of(k)) ? m_pw[k] + 1 : m_pw[k];
    else m_pw[k] = 0;
    if (eg[0]) m_rrp[k] = 1'b0;
    if (eg[1]) m_rrp[k] = 1'b1;
    last_g[k] = eg;
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) step(k);
  end

  always @(negedge rst_n) begin
    for (int k = 0; k < 2; k++) mreset(k);
  end

  task automatic drive(int k);
    if (!cpu_req[k] || last_g[k][0]) begin
      cpu_req[k] = ($urandom_range(99) < dens);
      cpu_we[k] = ($urandom_range(3) == 0);
      cpu_addr[k] = 12'h300 + 12'($urandom_range(15));
      cpu_wdata[k] = 8'($urandom);
    end else if ($urandom_range(19) == 0) begin
      cpu_req[k] = 1'b0;
    end
    if (!ppu_req[k] || last_g[k][1]) begin
      ppu_req[k] = ($urandom_range(99) < dens);
      ppu_we[k] = ($urandom_range(2) == 0);
      ppu_addr[k] = 12'h300 + 12'($urandom_range(15));
      ppu_wdata[k] = 8'($urandom);
    end else if ($urandom_range(19) == 0) begin
      ppu_req[k] = 1'b0;
    end
    if (!vid_req[k] || last_g[k][2]) begin
      vid_req[k] = ($urandom_range(99) < vdens);
      vid_addr[k] = 12'hF00 + 12'($urandom_range(15));
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (rnd_on) begin
      for (int k = 0; k < 2; k++) drive(k);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    for (int k = 0; k < 2; k++) begin
      cpu_req[k] = 0; ppu_req[k] = 0; vid_req[k] = 0;
      cpu_we[k] = 0; ppu_we[k] = 0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      cpu_addr[k] = '0; ppu_addr[k] = '0; vid_addr[k] = '0;
      cpu_wdata[k] = '0; ppu_wdata[k] = '0;
      for (int i = 0; i < 4096; i++) shm[k][i] = init_byte(i);
      mreset(k);
    end
    clear_in();

    // grants stay low while reset is held
    @(negedge clk);
    cpu_req[0] = 1; cpu_addr[0] = 12'h200;
    @(negedge clk);
    chk("rst_gate", 0, gnt[0], 3'b000);
    tick();
    rst_n = 1'b1;

    // single CPU read
    @(negedge clk);
    chk("rd_gnt", 0, gnt[0], 3'b001);
    chk("rd_raddr", 0, mra[0], 12'h200);
    tick();
    cpu_req[0] = 0;
    @(negedge clk);
    chk("rd_rv", 0, rv[0], 3'b001);
    chk("rd_data", 0, rdata[0], 8'hA2);
    chk("rd_idle", 0, gnt[0], 3'b000);
    tick();

    // CPU/ppu contention alternates, CPU first
    do_reset();
    cpu_req[0] = 1; cpu_addr[0] = 12'h300;
    ppu_req[0] = 1; ppu_addr[0] = 12'h301;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rr_gnt", 0, gnt[0], (i % 2 == 0) ? 3'b001 : 3'b010);
      if (i > 0)
        chk("rr_rv", 0, rv[0], (i % 2 == 0) ? 3'b010 : 3'b001);
      tick();
    end
    clear_in();

    // video burst limit
    vid_req[0] = 1; vid_addr[0] = 12'hF00;
    cpu_req[0] = 1; cpu_addr[0] = 12'h300;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("burst", 0, gnt[0], (i % 5 == 4) ? 3'b001 : 3'b100);
      tick();
    end
    cpu_req[0] = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("vid_only", 0, gnt[0], 3'b100);
      tick();
    end
    clear_in();

    // starvation guard on the 8/2 instance
    vid_req[1] = 1; vid_addr[1] = 12'hF01;
    ppu_req[1] = 1; ppu_addr[1] = 12'h302;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("starve", 1, gnt[1], (i % 3 == 2) ? 3'b010 : 3'b100);
      tick();
    end
    clear_in();

    // ppu write then CPU read-back
    ppu_req[0] = 1; ppu_we[0] = 1;
    ppu_addr[0] = 12'hF10; ppu_wdata[0] = 8'hFF;
    @(negedge clk);
    chk("wr_gnt", 0, gnt[0], 3'b010);
    chk("wr_we", 0, mwe[0], 1'b1);
    chk("wr_addr", 0, mwa[0], 12'hF10);
    chk("wr_d", 0, md[0], 8'hFF);
    tick();
    ppu_req[0] = 0; ppu_we[0] = 0;
    cpu_req[0] = 1; cpu_addr[0] = 12'hF10;
    @(negedge clk);
    chk("wb_gnt", 0, gnt[0], 3'b001);
    chk("wr_no_rv", 0, rv[0], 3'b000);
    chk("wb_we", 0, mwe[0], 1'b0);
    tick();
    cpu_req[0] = 0;
    @(negedge clk);
    chk("wb_rv", 0, rv[0], 3'b001);
    chk("wb_data", 0, rdata[0], 8'hFF);
    tick();

    // async reset kills an outstanding read
    cpu_req[0] = 1; cpu_addr[0] = 12'h200;
    @(negedge clk);
    chk("ar_gnt", 0, gnt[0], 3'b001);
    #2 rst_n = 1'b0;
    #1 chk("ar_gate", 0, gnt[0], 3'b000);
    tick();
    cpu_req[0] = 0;
    @(negedge clk);
    chk("ar_rv", 0, rv[0], 3'b000);
    tick();
    rst_n = 1'b1;
    cpu_req[0] = 1; cpu_addr[0] = 12'h300;
    ppu_req[0] = 1; ppu_addr[0] = 12'h301;
    @(negedge clk);
    chk("ar_rr", 0, gnt[0], 3'b001);
    tick();
    clear_in();
    tick();

    // randomized traffic
    rnd_on = 1'b1;
    for (int ph = 0; ph < 4; ph++) begin
      dens  = (ph == 0) ? 40 : (ph == 1) ? 95 : (ph == 2) ? 70 : 60;
      vdens = (ph == 0) ? 20 : (ph == 1) ? 95 : (ph == 2) ? 0 : 60;
      repeat (800) tick();
    end
    rnd_on = 1'b0;
    clear_in();
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/chip8_mem_arbiter.md
Name: chip8_mem_arbiter

Overview:
- Shares the single chip8_ram (one read port, one write port, 1-cycle synchronous read) between three requesters.
- Requesters: CPU core, ppu sprite engine (draw read/modify/write traffic) and video scanout (framebuffer reads).
- Video has bounded strict priority. CPU and ppu are round-robin arbitrated, with a starvation guard.
- Sits between the requesters and chip8_ram in the top level, replacing direct ppu-to-RAM wiring.

Parameters:
- ADDR_W, 12, RAM address width.
- DATA_W, 8, RAM data width.
- VIDEO_BURST, 4, maximum consecutive video grants while another requester waits.
- MAX_WAIT, 8, cycles a waiting CPU/ppu request may be denied before it is forced to win.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- cpu_req / ppu_req / vid_req  in  1 each  access request, held until granted.
- cpu_we / ppu_we  in  1 each  1 = write, 0 = read. Video is read-only.
- cpu_addr / ppu_addr / vid_addr  in  ADDR_W each  access address.
- cpu_wdata / ppu_wdata  in  DATA_W each  write data.
- cpu_gnt / ppu_gnt / vid_gnt  out  1 each  request accepted this cycle.
- cpu_rvalid / ppu_rvalid / vid_rvalid  out  1 each  rdata valid for that requester.
- rdata  out  DATA_W  read data; equals mem_q, shared by all requesters.
- mem_read_address  out  ADDR_W  to chip8_ram.read_address.
- mem_write_address  out  ADDR_W  to chip8_ram.write_address.
- mem_d  out  DATA_W  to chip8_ram.d.
- mem_we  out  1  to chip8_ram.we.
- mem_q  in  DATA_W  from chip8_ram.q.

Behaviour:
- Reset (reset=0), asynchronous:
  - All gnt, rvalid and mem_we are 0. Addresses and mem_d are 0.
  - rr_last = PPU, so the CPU wins the first CPU/ppu tie.
  - vid_run = 0; cpu_wait = ppu_wait = 0.
  - Grants are gated by reset, so no grant is issued while reset=0.
- Grant selection is combinational from reqs and registered state. At most one gnt per cycle (one-hot or zero). The selection order is:
  1. Forced: if cpu_wait or ppu_wait has reached MAX_WAIT and that requester is requesting, it wins. If both are saturated, CPU wins.
  2. Video: vid_req wins, unless vid_run == VIDEO_BURST and cpu_req|ppu_req is set.
  3. CPU/ppu round-robin: if both request, the one that is not rr_last wins. Otherwise the sole requester wins.
- Granted access reaches RAM in the same cycle:
  - Read: mem_read_address = granted addr.
  - Write: mem_write_address = addr, mem_d = wdata, mem_we = 1.
  - With no grant, mem_we = 0 and addresses hold their last value.
- Read latency:
  - A granted read asserts that requester's rvalid on the next cycle for exactly 1 cycle, with rdata = mem_q.
  - A granted write produces no rvalid.
- Back-to-back grants to the same requester are legal. rvalid pipelines at one per cycle.
- Requester rule: a requester keeps req, we, addr and wdata stable until it sees gnt. If it drops req before gnt, the access is abandoned with no side effect.
- Counters:
  - vid_run increments on a video grant (saturating at VIDEO_BURST) and clears on any non-video grant or on an idle cycle.
  - rr_last updates only on a CPU or ppu grant.
  - cpu_wait / ppu_wait increment (saturating at MAX_WAIT) each cycle that requester is requesting and not granted. They clear on that requester's grant or when its req is low.
- Same-address read and write in one cycle is impossible, since only one grant is issued. RAM read-during-write semantics are therefore never exercised.
- Reset mid-operation clears any pending rvalid. The outstanding read is lost and requesters must re-issue.

Decomposition:
- Shared package chip8_mem_pkg holds:
  - requester index constants REQ_CPU=0, REQ_PPU=1, REQ_VID=2;
  - the ADDR_W/DATA_W defaults;
  - FB_BASE = 12'hF00 framebuffer base, for use by ppu/video, not by the arbiter.
- One natural sub-module, chip8_rr_pick2: the two-way round-robin picker with starvation counters. The video priority and mux logic stay in the parent.

Test Plan:
- Single CPU read: after reset release, cpu_req=1, cpu_we=0, addr=12'h200, RAM[200]=8'hA2 → cpu_gnt the same cycle, cpu_rvalid the next cycle with rdata=8'hA2, other outputs 0.
- CPU/ppu contention: both req continuously, reads from 12'h300/12'h301 → grants alternate CPU, PPU, CPU, PPU… (CPU first after reset); each rvalid follows its grant by 1 cycle.
- Video burst limit: vid_req and cpu_req held with VIDEO_BURST=4 → four vid_gnt, one cpu_gnt, four vid_gnt, ...; with cpu_req low, vid_gnt every cycle.
- Starvation guard: MAX_WAIT=2, VIDEO_BURST=8, vid_req and ppu_req held → ppu_gnt issued on the cycle after ppu_wait reaches 2, i.e. the third cycle of waiting; vid_run clears.
- Write path: ppu_req=1, ppu_we=1, addr=12'hF10, wdata=8'hFF → mem_we=1 with mem_write_address=12'hF10, mem_d=8'hFF for 1 cycle, no rvalid; a subsequent CPU read of 12'hF10 returns 8'hFF.
- Async reset mid-read: cpu read granted, reset driven low before the next clock edge → cpu_rvalid stays 0, all gnt 0 while reset=0; after release, CPU wins the first CPU/ppu tie.
